// File: rtl/multi_echo_ranger.sv
// multi_echo_ranger: round-robin trigger/echo ranging engine for CH ultrasonic sensors.
// Optional build macro ECHO_DEGLITCH_EN adds a 3-cycle stability filter per echo input.
module multi_echo_ranger #(
  parameter  int CH         = 4,
  parameter  int CNT_W      = 16,
  parameter  int TRIG_US    = 10,
  parameter  int TIMEOUT_US = 30000,
  parameter  int GAP_US     = 60000,
  localparam int CH_W       = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic             clk_sys,
  input  logic             rst,
  input  logic             pluse_us,
  input  logic             fire,
  input  logic             cont_mode,
  input  logic [CH-1:0]    echo,
  output logic [CH-1:0]    trig,
  output logic             busy,
  output logic             res_vld,
  output logic [CH_W-1:0]  res_ch,
  output logic [CNT_W-1:0] res_data,
  output logic             res_err,
  output logic             done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_TRIG,
    S_WAIT_RISE,
    S_MEASURE,
    S_GAP
  } state_t;

  localparam logic [CNT_W-1:0] TRIG_LAST = CNT_W'(TRIG_US - 1);
  localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(TIMEOUT_US - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_US - 1);
  localparam logic [CH_W-1:0]  CH_LAST   = CH_W'(CH - 1);

  logic [CH-1:0] sync1_q, sync2_q, lvl, lvl_prev_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= echo;
      sync2_q <= sync1_q;
    end
  end

`ifdef ECHO_DEGLITCH_EN
  logic [CH-1:0] filt_q;
  logic [1:0]    stab_q [CH];

  // A level is accepted only after it has differed from the filtered value for 3 cycles.
  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      filt_q <= '0;
      // NOTE: this small counter array is reset like any register; it steers the filter output.
      for (int i = 0; i < CH; i++) stab_q[i] <= 2'd0;
    end else begin
      for (int i = 0; i < CH; i++) begin
        if (sync2_q[i] == filt_q[i]) begin
          stab_q[i] <= 2'd0;
        end else if (stab_q[i] == 2'd2) begin
          filt_q[i] <= sync2_q[i];
          stab_q[i] <= 2'd0;
        end else begin
          stab_q[i] <= stab_q[i] + 2'd1;
        end
      end
    end
  end

  assign lvl = filt_q;
`else
  assign lvl = sync2_q;
`endif

  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) lvl_prev_q <= '0;
    else     lvl_prev_q <= lvl;
  end

  state_t            state_q, state_d;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
  logic              res_vld_q, res_vld_d;
  logic [CH_W-1:0]   res_ch_q, res_ch_d;
  logic [CNT_W-1:0]  res_data_q, res_data_d;
  logic              res_err_q, res_err_d;
  logic              done_q, done_d;
  logic              lvl_ch, rise_ch, fall_ch;

  assign lvl_ch  = lvl[ch_q];
  assign rise_ch = lvl_ch & ~lvl_prev_q[ch_q];
  assign fall_ch = ~lvl_ch & lvl_prev_q[ch_q];
  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d    = state_q;
    ch_d       = ch_q;
    cnt_d      = cnt_q;
    res_vld_d  = 1'b0;
    res_ch_d   = res_ch_q;
    res_data_d = res_data_q;
    res_err_d  = res_err_q;
    done_d     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        // done_q marks the IDLE-return cycle, during which the engine still reports busy.
        if (fire && !done_q) begin
          state_d = S_TRIG;
          ch_d    = '0;
          cnt_d   = '0;
        end
      end
      S_TRIG: begin
        if (pluse_us) begin
          if (cnt_q == TRIG_LAST) begin
            state_d = S_WAIT_RISE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      S_WAIT_RISE: begin
        if (rise_ch) begin
          state_d = S_MEASURE;
          cnt_d   = '0;
        end else if (pluse_us) begin
          if (cnt_q == TMO_LAST) begin
            res_vld_d  = 1'b1;
            res_ch_d   = ch_q;
            res_data_d = '1;
            res_err_d  = 1'b1;
            state_d    = S_GAP;
            cnt_d      = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      S_MEASURE: begin
        if (fall_ch) begin
          res_vld_d  = 1'b1;
          res_ch_d   = ch_q;
          res_data_d = cnt_q;
          res_err_d  = 1'b0;
          state_d    = S_GAP;
          cnt_d      = '0;
        end else if (pluse_us && lvl_ch) begin
          if (cnt_q == TMO_LAST) begin
            res_vld_d  = 1'b1;
            res_ch_d   = ch_q;
            res_data_d = '1;
            res_err_d  = 1'b1;
            state_d    = S_GAP;
            cnt_d      = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      S_GAP: begin
        if (pluse_us) begin
          if (cnt_q == GAP_LAST) begin
            cnt_d = '0;
            if (ch_q != CH_LAST) begin
              ch_d    = ch_q + 1'b1;
              state_d = S_TRIG;
            end else begin
              done_d  = 1'b1;
              ch_d    = '0;
              state_d = cont_mode ? S_TRIG : S_IDLE;
            end
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      ch_q       <= '0;
      cnt_q      <= '0;
      res_vld_q  <= 1'b0;
      res_ch_q   <= '0;
      res_data_q <= '0;
      res_err_q  <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ch_q       <= ch_d;
      cnt_q      <= cnt_d;
      res_vld_q  <= res_vld_d;
      res_ch_q   <= res_ch_d;
      res_data_q <= res_data_d;
      res_err_q  <= res_err_d;
      done_q     <= done_d;
    end
  end

  // Decoded from registers only, so an asynchronous reset drops the trigger at once.
  always_comb begin
    trig = '0;
    if (state_q == S_TRIG) trig[ch_q] = 1'b1;
  end

  assign busy     = (state_q != S_IDLE) | done_q;
  assign res_vld  = res_vld_q;
  assign res_ch   = res_ch_q;
  assign res_data = res_data_q;
  assign res_err  = res_err_q;
  assign done     = done_q;

endmodule

// File: tb/tb_multi_echo_ranger.sv
// tb_multi_echo_ranger: directed scans with randomized echo timing, checked against a
// behavioural per-channel result model (echo width in us, or timeout).
`timescale 1ns/1ps
module tb_multi_echo_ranger;

  localparam int CH         = 4;
  localparam int CNT_W      = 16;
  localparam int TRIG_US    = 10;
  localparam int TIMEOUT_US = 100;
  localparam int GAP_US     = 20;
  localparam int US_CLK     = 4;
`ifdef ECHO_DEGLITCH_EN
  localparam int SYNC_LAT   = 6;
`else
  localparam int SYNC_LAT   = 3;
`endif

  typedef enum int {E_NORMAL, E_NONE, E_STUCK} echo_mode_t;

  logic             clk_sys = 1'b0;
  logic             rst;
  logic             pluse_us;
  logic             fire;
  logic             cont_mode;
  logic [CH-1:0]    echo;
  logic [CH-1:0]    trig;
  logic             busy;
  logic             res_vld;
  logic [1:0]       res_ch;
  logic [CNT_W-1:0] res_data;
  logic             res_err;
  logic             done;

  int n_checks = 0;
  int n_fail   = 0;

  multi_echo_ranger #(
    .CH(CH), .CNT_W(CNT_W), .TRIG_US(TRIG_US), .TIMEOUT_US(TIMEOUT_US), .GAP_US(GAP_US)
  ) dut (
    .clk_sys(clk_sys), .rst(rst), .pluse_us(pluse_us), .fire(fire), .cont_mode(cont_mode),
    .echo(echo), .trig(trig), .busy(busy), .res_vld(res_vld), .res_ch(res_ch),
    .res_data(res_data), .res_err(res_err), .done(done)
  );

  always #5 clk_sys = ~clk_sys;

  initial begin
    pluse_us = 1'b0;
    forever begin
      repeat (US_CLK - 1) @(posedge clk_sys);
      #1 pluse_us = 1'b1;
      @(posedge clk_sys);
      #1 pluse_us = 1'b0;
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_range(input string tag, input int obs, input int lo, input int hi);
    logic ok;
    ok = (obs >= lo) && (obs <= hi);
    n_checks++;
    assert (ok === 1'b1) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
    end
  endtask

  // Reference model: what a channel should report for a given echo behaviour.
  function automatic void model_result(input echo_mode_t mode, input int wid,
                                       output logic err, output int lo, output int hi);
    if (mode == E_NONE || wid >= TIMEOUT_US) begin
      err = 1'b1;
      lo  = (1 << CNT_W) - 1;
      hi  = (1 << CNT_W) - 1;
    end else begin
      err = 1'b0;
      lo  = wid - 1;
      hi  = wid + 1;
    end
  endfunction

  task automatic start_scan();
    fire = 1'b1;
    step();
    fire = 1'b0;
    check("fire_trig0", trig, 32'd1);
    check("fire_busy", busy, 32'd1);
  endtask

  task automatic wait_trig(input int k);
    int n = 0;
    while (trig === '0 && n < 2000) begin step(); n++; end
    check($sformatf("trig_order_ch%0d", k), trig, 32'(1 << k));
    n = 0;
    while (trig !== '0 && n < 200) begin step(); n++; end
    check_range($sformatf("trig_width_ch%0d", k), n, 35, 44);
  endtask

  task automatic run_channel(input int k, input echo_mode_t mode, input int dly, input int wid);
    int   n = 0;
    logic err;
    int   lo, hi;
    model_result(mode, wid, err, lo, hi);
    wait_trig(k);
    case (mode)
      E_NORMAL: begin
        repeat (dly * US_CLK) step();
        echo[k] = 1'b1;
        repeat (wid * US_CLK) step();
        echo[k] = 1'b0;
        while (res_vld !== 1'b1 && n < 50) begin step(); n++; end
        check($sformatf("fall_latency_ch%0d", k), n, SYNC_LAT);
      end
      E_NONE: begin
        while (res_vld !== 1'b1 && n < 800) begin step(); n++; end
        check_range($sformatf("rise_timeout_ch%0d", k), n, 394, 404);
      end
      default: begin
        repeat (dly * US_CLK) step();
        echo[k] = 1'b1;
        while (res_vld !== 1'b1 && n < 800) begin step(); n++; end
        check_range($sformatf("meas_timeout_ch%0d", k), n, SYNC_LAT + 394, SYNC_LAT + 404);
      end
    endcase
    check($sformatf("res_vld_ch%0d", k), res_vld, 32'd1);
    check($sformatf("res_ch_ch%0d", k), res_ch, 32'(k));
    check($sformatf("res_err_ch%0d", k), res_err, 32'(err));
    check_range($sformatf("res_data_ch%0d", k), int'(res_data), lo, hi);
    check($sformatf("done_not_vld_ch%0d", k), done, 32'd0);
    step();
    echo[k] = 1'b0;
    check($sformatf("res_vld_strobe_ch%0d", k), res_vld, 32'd0);
    check_range($sformatf("res_hold_ch%0d", k), int'(res_data), lo, hi);
  endtask

  task automatic wait_done(input logic cont, input logic fire_at_done);
    int n = 0;
    while (done !== 1'b1 && n < 400) begin step(); n++; end
    check("done_seen", done, 32'd1);
    check("busy_at_done", busy, 32'd1);
    check("vld_not_at_done", res_vld, 32'd0);
    check("trig_at_done", trig, cont ? 32'd1 : 32'd0);
    fire = fire_at_done;
    step();
    fire = 1'b0;
    check("done_strobe", done, 32'd0);
    check("busy_after_done", busy, 32'(cont));
    if (!cont) begin
      repeat (60) step();
      check("idle_trig", trig, 32'd0);
      check("idle_busy", busy, 32'd0);
    end
  endtask

  initial begin
    echo      = '0;
    fire      = 1'b0;
    cont_mode = 1'b0;
    rst       = 1'b1;
    repeat (3) step();
    check("rst_trig", trig, 32'd0);
    check("rst_busy", busy, 32'd0);
    check("rst_res_vld", res_vld, 32'd0);
    check("rst_done", done, 32'd0);
    check("rst_res_ch", res_ch, 32'd0);
    check("rst_res_data", res_data, 32'd0);
    check("rst_res_err", res_err, 32'd0);
    rst = 1'b0;
    repeat (5) step();
    check("idle_no_fire", busy, 32'd0);

    // Directed scan: echo 25 us after trigger, 37 us wide, on every channel.
    start_scan();
    for (int k = 0; k < CH; k++) run_channel(k, E_NORMAL, 25, 37);
    wait_done(1'b0, 1'b0);

    // Missing echo on ch 2, stuck echo on ch 1, fire mid-scan and at done are ignored.
    start_scan();
    run_channel(0, E_NORMAL, $urandom_range(5, 60), $urandom_range(5, 90));
    run_channel(1, E_STUCK, $urandom_range(5, 60), 150);
    fire = 1'b1;
    step();
    fire = 1'b0;
    run_channel(2, E_NONE, 0, 0);
    run_channel(3, E_NORMAL, $urandom_range(5, 60), $urandom_range(5, 90));
    wait_done(1'b0, 1'b1);

    // Continuous mode: two scans, cont_mode dropped during the second.
    cont_mode = 1'b1;
    start_scan();
    for (int k = 0; k < CH; k++)
      run_channel(k, E_NORMAL, $urandom_range(5, 60), $urandom_range(5, 90));
    wait_done(1'b1, 1'b0);
    for (int k = 0; k < CH; k++) begin
      run_channel(k, E_NORMAL, $urandom_range(5, 60), $urandom_range(5, 90));
      if (k == 1) cont_mode = 1'b0;
    end
    wait_done(1'b0, 1'b0);

    // Asynchronous reset during MEASURE of ch 1.
    start_scan();
    run_channel(0, E_NORMAL, $urandom_range(5, 60), $urandom_range(5, 90));
    wait_trig(1);
    repeat (40) step();
    echo[1] = 1'b1;
    repeat (40) step();
    #3 rst = 1'b1;
    #1;
    check("mrst_trig", trig, 32'd0);
    check("mrst_busy", busy, 32'd0);
    check("mrst_res_data", res_data, 32'd0);
    check("mrst_res_ch", res_ch, 32'd0);
    check("mrst_res_err", res_err, 32'd0);
    repeat (3) step();
    rst     = 1'b0;
    echo[1] = 1'b0;
    begin
      logic vld_seen = 1'b0;
      logic busy_seen = 1'b0;
      repeat (400) begin
        step();
        vld_seen  |= res_vld;
        busy_seen |= busy;
      end
      check("mrst_no_vld", vld_seen, 32'd0);
      check("mrst_no_busy", busy_seen, 32'd0);
    end

    // Short glitches on echo[0] during WAIT_RISE.
    start_scan();
    wait_trig(0);
    repeat (20) step();
    echo[0] = 1'b1;
    repeat (2) step();
    echo[0] = 1'b0;
`ifdef ECHO_DEGLITCH_EN
    begin
      logic vld_seen = 1'b0;
      repeat (40) begin
        step();
        vld_seen |= res_vld;
      end
      check("glitch2_ignored", vld_seen, 32'd0);
    end
    echo[0] = 1'b1;
    repeat (5) step();
    echo[0] = 1'b0;
`endif
    begin
      int n = 0;
      while (res_vld !== 1'b1 && n < 60) begin step(); n++; end
      check("glitch_vld", res_vld, 32'd1);
      check("glitch_ch", res_ch, 32'd0);
      check("glitch_err", res_err, 32'd0);
      check_range("glitch_data", int'(res_data), 0, 2);
    end
    for (int k = 1; k < CH; k++)
      run_channel(k, E_NORMAL, $urandom_range(5, 60), $urandom_range(5, 90));
    wait_done(1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
